intersection_phase_arbiter: RTL and testbench

- Arbitrates the shared intersection between three requesters: main road (default owner), side road (vehicle sensor) and pedestrians (walk button).
- Latches requests and sequences safe phase changes: green, yellow, all-red, served phase, all-red, back to main.
- Round-robins side and walk service so neither starves.
- Drives the lamp outputs directly. Timing is counted in tick_en pulses; at the system 1 Hz clock, tick_en is tied high.

---
 rtl/intersection_phase_arbiter.sv | 157 +++++++++++++++
 tb/tb_intersection_phase_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_arbiter.sv
// Three-way intersection arbiter: main road owns the junction by default, side-road
// and pedestrian requests are latched and served round-robin through yellow/all-red phases.
module intersection_phase_arbiter #(
  parameter int unsigned MAIN_MIN_T = 10,
  parameter int unsigned YELLOW_T   = 2,
  parameter int unsigned ALLRED_T   = 1,
  parameter int unsigned SIDE_T     = 6,
  parameter int unsigned WALK_T     = 5,
  parameter int unsigned TW         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       sensor,
  input  logic       walk_button,
  output logic       main_green,
  output logic       main_yellow,
  output logic       main_red,
  output logic       side_green,
  output logic       side_yellow,
  output logic       side_red,
  output logic       walk_lamp,
  output logic [2:0] phase,
  output logic       side_pend,
  output logic       walk_pend
);

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    ALL_RED = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    WALK    = 3'd5,
    CLEAR   = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] cnt;
  logic [TW-1:0] dur;
  logic          expired;
  logic          rr;
  logic          enter_side;
  logic          enter_walk;

  always_comb begin
    dur = TW'(ALLRED_T);
    case (state)
      MAIN_G:         dur = TW'(MAIN_MIN_T);
      MAIN_Y, SIDE_Y: dur = TW'(YELLOW_T);
      ALL_RED, CLEAR: dur = TW'(ALLRED_T);
      SIDE_G:         dur = TW'(SIDE_T);
      WALK:           dur = TW'(WALK_T);
      default:        dur = TW'(ALLRED_T);
    endcase
  end

  // A state of duration D leaves on the tick where cnt reaches D-1, i.e. after exactly D ticks.
  assign expired    = tick_en && (cnt == dur - 1'b1);
  assign enter_side = (state_nx == SIDE_G) && (state != SIDE_G);
  assign enter_walk = (state_nx == WALK) && (state != WALK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MAIN_G;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MAIN_G:  if (expired && (side_pend || walk_pend)) state_nx = MAIN_Y;
      MAIN_Y:  if (expired) state_nx = ALL_RED;
      ALL_RED: if (expired) begin
        if (side_pend && (!walk_pend || !rr)) state_nx = SIDE_G;
        else if (walk_pend)                   state_nx = WALK;
        else                                  state_nx = CLEAR;
      end
      SIDE_G:  if (expired) state_nx = SIDE_Y;
      SIDE_Y:  if (expired) state_nx = CLEAR;
      WALK:    if (expired) state_nx = CLEAR;
      CLEAR:   if (expired) state_nx = MAIN_G;
      default: state_nx = MAIN_G;
    endcase
  end

  // Main green holds its count at MAIN_MIN_T-1 so a late request exits on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (tick_en && !(state == MAIN_G && cnt == dur - 1'b1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_pend <= 1'b0;
      walk_pend <= 1'b0;
      rr        <= 1'b0;
    end else begin
      if (enter_side)
        side_pend <= 1'b0;
      else if (sensor && state != SIDE_G && state != SIDE_Y)
        side_pend <= 1'b1;

      if (enter_walk)
        walk_pend <= 1'b0;
      else if (walk_button && state != WALK)
        walk_pend <= 1'b1;

      if (enter_side)      rr <= 1'b1;
      else if (enter_walk) rr <= 1'b0;
    end
  end

  always_comb begin
    main_green  = 1'b0;
    main_yellow = 1'b0;
    main_red    = 1'b0;
    side_green  = 1'b0;
    side_yellow = 1'b0;
    side_red    = 1'b0;
    walk_lamp   = 1'b0;
    case (state)
      MAIN_G: begin
        main_green = 1'b1;
        side_red   = 1'b1;
      end
      MAIN_Y: begin
        main_yellow = 1'b1;
        side_red    = 1'b1;
      end
      SIDE_G: begin
        main_red   = 1'b1;
        side_green = 1'b1;
      end
      SIDE_Y: begin
        main_red    = 1'b1;
        side_yellow = 1'b1;
      end
      WALK: begin
        main_red  = 1'b1;
        side_red  = 1'b1;
        walk_lamp = 1'b1;
      end
      default: begin
        main_red = 1'b1;
        side_red = 1'b1;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed bench for intersection_phase_arbiter: expected phase/lamp/pending values are
// queued as each cycle is driven and checked against the DUT after the following edge.
module tb_intersection_phase_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en;
  logic       sensor;
  logic       walk_button;
  logic       main_green, main_yellow, main_red;
  logic       side_green, side_yellow, side_red;
  logic       walk_lamp;
  logic [2:0] phase;
  logic       side_pend, walk_pend;

  intersection_phase_arbiter #(
    .MAIN_MIN_T(10), .YELLOW_T(2), .ALLRED_T(1), .SIDE_T(6), .WALK_T(5), .TW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .sensor(sensor), .walk_button(walk_button),
    .main_green(main_green), .main_yellow(main_yellow), .main_red(main_red),
    .side_green(side_green), .side_yellow(side_yellow), .side_red(side_red),
    .walk_lamp(walk_lamp), .phase(phase), .side_pend(side_pend), .walk_pend(walk_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scn;
    int         cyc;
    logic [2:0] ph;
    logic       sp;
    logic       wp;
    logic       chk_pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Phase schedule in ticks: side service, then (schedule 2) a following walk service.
  localparam int SCH_PH [11] = '{0, 1, 2, 3, 4, 6, 0, 1, 2, 5, 6};
  localparam int SCH_LEN[11] = '{10, 2, 1, 6, 2, 1, 10, 2, 1, 5, 1};

  function automatic logic [2:0] exp_phase(input int sch, input int k, input int div);
    int n;
    int acc;
    n   = (sch == 0) ? 0 : (sch == 1) ? 6 : 11;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (k < acc + SCH_LEN[i] * div) return 3'(SCH_PH[i]);
      acc += SCH_LEN[i] * div;
    end
    return 3'd0;
  endfunction

  // {main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_lamp}
  function automatic logic [6:0] lamps_of(input logic [2:0] p);
    case (p)
      3'd0:       return 7'b1000010;
      3'd1:       return 7'b0100010;
      3'd2, 3'd6: return 7'b0010010;
      3'd3:       return 7'b0011000;
      3'd4:       return 7'b0010100;
      3'd5:       return 7'b0010011;
      default:    return 7'b0000000;
    endcase
  endfunction

  task automatic check_front();
    exp_t       e;
    logic [6:0] lamps;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e     = exp_q.pop_front();
    lamps = {main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_lamp};
    n_vec++;
    assert (phase === e.ph) else begin
      n_err++;
      $error("FAIL s%0d phase cyc %0d got %0d exp %0d", e.scn, e.cyc, phase, e.ph);
    end
    n_vec++;
    assert (lamps === lamps_of(e.ph)) else begin
      n_err++;
      $error("FAIL s%0d lamps cyc %0d got %b exp %b", e.scn, e.cyc, lamps, lamps_of(e.ph));
    end
    if (e.chk_pend) begin
      n_vec++;
      assert (side_pend === e.sp) else begin
        n_err++;
        $error("FAIL s%0d side_pend cyc %0d got %b exp %b", e.scn, e.cyc, side_pend, e.sp);
      end
      n_vec++;
      assert (walk_pend === e.wp) else begin
        n_err++;
        $error("FAIL s%0d walk_pend cyc %0d got %b exp %b", e.scn, e.cyc, walk_pend, e.wp);
      end
    end
  endtask

  task automatic do_reset(input int scn);
    exp_t e;
    rst_n       = 1'b0;
    tick_en     = 1'b0;
    sensor      = 1'b0;
    walk_button = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = '{scn: scn, cyc: 0, ph: 3'd0, sp: 1'b0, wp: 1'b0, chk_pend: 1'b1};
    exp_q.push_back(e);
    #1 check_front();
  endtask

  // Drives n cycles from reset; sensor pulses at s_a and is held over [s_h0, s_h1].
  task automatic run(input int scn, input int n, input int div, input int sch,
                     input int s_a, input int s_h0, input int s_h1, input int w_a);
    logic       sp, wp, s, w, t;
    logic [2:0] ph, phn;
    exp_t       e;
    do_reset(scn);
    sp = 1'b0;
    wp = 1'b0;
    for (int k = 0; k < n; k++) begin
      s   = (k == s_a) || (k >= s_h0 && k <= s_h1);
      w   = (k == w_a);
      t   = ((k % div) == (div - 1));
      ph  = exp_phase(sch, k, div);
      phn = exp_phase(sch, k + 1, div);
      sensor      = s;
      walk_button = w;
      tick_en     = t;
      sp = (sp | (s && ph != 3'd3 && ph != 3'd4)) & !(phn == 3'd3 && ph != 3'd3);
      wp = (wp | (w && ph != 3'd5)) & !(phn == 3'd5 && ph != 3'd5);
      e = '{scn: scn, cyc: k + 1, ph: phn, sp: sp, wp: wp,
            chk_pend: !((phn == 3'd3 && ph != 3'd3) || (phn == 3'd5 && ph != 3'd5))};
      exp_q.push_back(e);
      @(posedge clk);
      #1 check_front();
      @(negedge clk);
    end
    sensor      = 1'b0;
    walk_button = 1'b0;
    tick_en     = 1'b0;
  endtask

  initial begin
    exp_t e;

    // 1: idle main road
    run(1, 40, 1, 0, -1, -1, -2, -1);
    // 2: single side request
    run(2, 40, 1, 1, 3, -1, -2, -1);
    // 3: simultaneous side and walk, side first then walk
    run(3, 50, 1, 2, 3, -1, -2, 3);
    // 4: tick one clock in four
    run(4, 120, 4, 1, 0, -1, -2, -1);

    // 5: asynchronous reset mid side-green with a walk pending
    run(5, 15, 1, 2, 3, -1, -2, 3);
    #2 rst_n = 1'b0;
    e = '{scn: 5, cyc: 15, ph: 3'd0, sp: 1'b0, wp: 1'b0, chk_pend: 1'b1};
    exp_q.push_back(e);
    #1 check_front();

    // 6: sensor held only while side is served is ignored; main rests afterwards
    run(6, 70, 1, 1, 3, 13, 20, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
